platform_field: RTL and testbench

- Parametrised platform manager for the Doodle Jump playfield. It holds N_PLAT platforms, moves them horizontally with a bounce inside [X_MIN, X_MAX], and scrolls them down by a per-frame camera amount.
- A platform that scrolls off the bottom respawns at the top with LFSR-random X, speed and mobility.
- Updates are serial, one platform per clock, once per frame tick. Position arrays feed the renderer and the collision logic.

---
 rtl/platform_field_pkg.sv | 22 ++
 rtl/platform_field_lfsr16.sv | 25 ++
 rtl/platform_field.sv | 168 ++++++++++++++++
 tb/tb_platform_field.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/platform_field_pkg.sv
// Shared types and default playfield geometry for the platform manager.
// The layout helper is a constant function so it can seed reset values.
package platform_pkg;

  typedef logic [9:0] coord_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    UPDATE = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam int H_DEFAULT      = 480;
  localparam int X_MIN_DEFAULT  = 140;
  localparam int X_MAX_DEFAULT  = 499;
  localparam int PLAT_W_DEFAULT = 60;

  function automatic coord_t init_x(input int i, input int xmin, input int range);
    return coord_t'(xmin + ((40 * i) % range));
  endfunction

endpackage

// File: rtl/platform_field_lfsr16.sv
// Free-running 16-bit Galois LFSR (taps 16'hB400), loaded with seed on Reset.
// Only the low OUT_W bits are exposed to the consumer.
module lfsr16 #(
  parameter int OUT_W = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [15:0]      seed,
  output logic [OUT_W-1:0] value
);

  logic [15:0] q;

  // Right-shifting Galois step, feedback taken from the bit shifted out.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      q <= seed;
    end else begin
      q <= {1'b0, q[15:1]} ^ (q[0] ? 16'hB400 : 16'h0000);
    end
  end

  assign value = q[OUT_W-1:0];

endmodule

// File: rtl/platform_field.sv
// Platform manager: one platform updated per clock on each frame tick,
// horizontal bounce inside [X_MIN, XR] and downward scroll with top respawn.
module platform_field
  import platform_pkg::*;
#(
  parameter int          N_PLAT = 8,
  parameter int          H      = H_DEFAULT,
  parameter int          X_MIN  = X_MIN_DEFAULT,
  parameter int          X_MAX  = X_MAX_DEFAULT,
  parameter int          PLAT_W = PLAT_W_DEFAULT,
  parameter logic [15:0] SEED   = 16'hACE1
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    frame_tick,
  input  logic                    init,
  input  logic                    scroll_valid,
  input  logic [3:0]              scroll_px,
  output logic [0:N_PLAT-1][9:0]  Platform_X_out,
  output logic [0:N_PLAT-1][9:0]  Platform_Y_out,
  output logic [N_PLAT-1:0]       Platform_moving,
  output logic                    busy,
  output logic                    frame_done,
  output logic                    overrun
);

  localparam int XR    = X_MAX - PLAT_W + 1;
  localparam int RANGE = XR - X_MIN + 1;
  localparam int IW    = $clog2(N_PLAT);

  localparam logic [10:0]   XR_C    = 11'(XR);
  localparam logic [10:0]   XMIN_C  = 11'(X_MIN);
  localparam logic [10:0]   H_C     = 11'(H);
  localparam logic [10:0]   RANGE_C = 11'(RANGE);
  localparam logic [IW-1:0] LAST    = IW'(N_PLAT - 1);

  state_t state, state_nx;
  logic [IW-1:0] idx;
  logic [3:0]    scroll;
  logic [12:0]   rnd;

  logic [0:N_PLAT-1][9:0] px, py, init_px, init_py;
  logic [N_PLAT-1:0]      mov, dir_left, init_mov;
  logic [N_PLAT-1:0][1:0] spd, init_spd;

  logic [10:0] cx, sp, ny, r;
  coord_t      upd_x, upd_y;
  logic        upd_mov, upd_dir;
  logic [1:0]  upd_spd;

  lfsr16 #(.OUT_W(13)) u_lfsr (
    .Clk   (Clk),
    .Reset (Reset),
    .seed  (SEED),
    .value (rnd)
  );

  for (genvar g = 0; g < N_PLAT; g++) begin : g_layout
    assign init_px[g]  = init_x(g, X_MIN, RANGE);
    assign init_py[g]  = coord_t'(g * (H / N_PLAT));
    assign init_mov[g] = 1'(g % 2);
    assign init_spd[g] = 2'((g % 3) + 1);
  end

  // Next position/attributes of the platform currently selected by idx.
  always_comb begin
    cx      = {1'b0, px[idx]};
    sp      = {9'd0, spd[idx]};
    ny      = {1'b0, py[idx]} + {7'd0, scroll};
    r       = {2'b00, rnd[8:0]};
    upd_x   = px[idx];
    upd_y   = py[idx];
    upd_mov = mov[idx];
    upd_spd = spd[idx];
    upd_dir = dir_left[idx];
    if (!mov[idx]) begin
      upd_x = px[idx];
    end else if (!dir_left[idx]) begin
      if (cx + sp >= XR_C) begin
        upd_x   = 10'(XR_C);
        upd_dir = 1'b1;
      end else begin
        upd_x = 10'(cx + sp);
      end
    end else begin
      if (cx <= XMIN_C + sp) begin
        upd_x   = 10'(XMIN_C);
        upd_dir = 1'b0;
      end else begin
        upd_x = 10'(cx - sp);
      end
    end
    // Wrapping keeps the vertical spacing; the respawn overrides the bounce.
    if (ny > H_C - 11'd1) begin
      upd_y   = 10'(ny - H_C);
      upd_x   = 10'(XMIN_C + ((r >= RANGE_C) ? r - RANGE_C : r));
      upd_mov = rnd[9];
      upd_spd = 2'd1 + ((rnd[11:10] == 2'd3) ? 2'd0 : rnd[11:10]);
      upd_dir = rnd[12];
    end else begin
      upd_y = 10'(ny);
    end
  end

  // Pass sequencing; init always returns to IDLE and discards the pass.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (frame_tick) state_nx = UPDATE;
        else            state_nx = IDLE;
      end
      UPDATE: begin
        if (idx == LAST) state_nx = DONE;
        else             state_nx = UPDATE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (init) state_nx = IDLE;
  end

  // State, pass bookkeeping and the in-place platform arrays.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state    <= IDLE;
      idx      <= '0;
      scroll   <= 4'd0;
      px       <= init_px;
      py       <= init_py;
      mov      <= init_mov;
      spd      <= init_spd;
      dir_left <= '0;
    end else if (init) begin
      state    <= IDLE;
      idx      <= '0;
      scroll   <= 4'd0;
      px       <= init_px;
      py       <= init_py;
      mov      <= init_mov;
      spd      <= init_spd;
      dir_left <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && frame_tick) begin
        idx    <= '0;
        scroll <= scroll_valid ? scroll_px : 4'd0;
      end else if (state == UPDATE) begin
        idx           <= idx + 1'b1;
        px[idx]       <= upd_x;
        py[idx]       <= upd_y;
        mov[idx]      <= upd_mov;
        spd[idx]      <= upd_spd;
        dir_left[idx] <= upd_dir;
      end else begin
        idx <= idx;
      end
    end
  end

  assign Platform_X_out  = px;
  assign Platform_Y_out  = py;
  assign Platform_moving = mov;
  assign busy            = (state != IDLE);
  assign frame_done      = (state == DONE);
  assign overrun         = frame_tick & (state != IDLE) & ~init;

endmodule

// File: tb/tb_platform_field.sv
// Directed + randomized bench for platform_field with a behavioural model
// of the playfield driven by a recorded per-cycle LFSR history.
module tb_platform_field;

  localparam int NP    = 8;
  localparam int HH    = 480;
  localparam int XMIN  = 140;
  localparam int XR    = 440;
  localparam int RANGE = 301;
  localparam logic [15:0] SEED = 16'hACE1;

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  logic frame_tick = 1'b0;
  logic init = 1'b0;
  logic scroll_valid = 1'b0;
  logic [3:0] scroll_px = 4'd0;
  logic [0:NP-1][9:0] Platform_X_out, Platform_Y_out;
  logic [NP-1:0] Platform_moving;
  logic busy, frame_done, overrun;

  platform_field #(
    .N_PLAT(NP), .H(HH), .X_MIN(XMIN), .X_MAX(499), .PLAT_W(60), .SEED(SEED)
  ) dut (
    .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .init(init),
    .scroll_valid(scroll_valid), .scroll_px(scroll_px),
    .Platform_X_out(Platform_X_out), .Platform_Y_out(Platform_Y_out),
    .Platform_moving(Platform_moving), .busy(busy), .frame_done(frame_done),
    .overrun(overrun)
  );

  always #5 Clk = ~Clk;

  // Reference random source: value present before each rising edge.
  logic [15:0] m_lfsr;
  logic [15:0] hist [0:8191];
  int cyc = 0;

  always @(posedge Clk or posedge Reset) begin
    if (Reset) m_lfsr <= SEED;
    else       m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
  end

  always @(posedge Clk) begin
    hist[cyc] <= m_lfsr;
    cyc <= cyc + 1;
  end

  int mx [NP], my [NP], mmov [NP], mspd [NP], mdir [NP];
  int nchk = 0, npass = 0;

  task automatic check(input string tag, input int obs, input int exp);
    nchk++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic model_layout();
    for (int i = 0; i < NP; i++) begin
      my[i] = i * (HH / NP);
      mx[i] = XMIN + ((40 * i) % RANGE);
      mmov[i] = i % 2;
      mspd[i] = (i % 3) + 1;
      mdir[i] = 0;
    end
  endtask

  task automatic model_pass(input int tc, input int s);
    for (int i = 0; i < NP; i++) begin
      int l, nx, ny, rr;
      l = int'(hist[tc + 1 + i]);
      if (mmov[i] == 1) begin
        if (mdir[i] == 0) begin
          nx = mx[i] + mspd[i];
          if (nx >= XR) begin mx[i] = XR; mdir[i] = 1; end
          else mx[i] = nx;
        end else begin
          if (mx[i] <= XMIN + mspd[i]) begin mx[i] = XMIN; mdir[i] = 0; end
          else mx[i] = mx[i] - mspd[i];
        end
      end
      ny = my[i] + s;
      if (ny > HH - 1) begin
        my[i] = ny - HH;
        rr = l % 512;
        mx[i] = XMIN + ((rr >= RANGE) ? rr - RANGE : rr);
        mmov[i] = (l / 512) % 2;
        mspd[i] = 1 + (((l / 1024) % 4) % 3);
        mdir[i] = (l / 4096) % 2;
      end else begin
        my[i] = ny;
      end
    end
  endtask

  task automatic compare_all(input string tag);
    for (int i = 0; i < NP; i++) begin
      check($sformatf("%s_x%0d", tag, i), int'(Platform_X_out[i]), mx[i]);
      check($sformatf("%s_y%0d", tag, i), int'(Platform_Y_out[i]), my[i]);
      check($sformatf("%s_mov%0d", tag, i), int'(Platform_moving[i]), mmov[i]);
    end
  endtask

  // One frame: tick, watch a bounded window, then update and compare the model.
  task automatic do_pass(input int s, input logic v, input bit timing, input string tag);
    int tc, busy_cnt, done_at, dones;
    @(negedge Clk);
    frame_tick = 1'b1; scroll_valid = v; scroll_px = 4'(s);
    tc = cyc;
    @(negedge Clk);
    frame_tick = 1'b0;
    busy_cnt = 0; done_at = 0; dones = 0;
    for (int k = 1; k <= 12; k++) begin
      if (busy) busy_cnt++;
      if (frame_done) begin dones++; if (done_at == 0) done_at = k; end
      @(negedge Clk);
    end
    check({tag, "_done_count"}, dones, 1);
    if (timing) begin
      check({tag, "_busy_cycles"}, busy_cnt, 9);
      check({tag, "_done_cycle"}, done_at, 9);
    end
    model_pass(tc, v ? s : 0);
    compare_all(tag);
  endtask

  initial begin
    int tc, dones, y7exp [4];
    y7exp = '{435, 450, 465, 0};
    model_layout();
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    check("rst_x3", int'(Platform_X_out[3]), 260);
    check("rst_y3", int'(Platform_Y_out[3]), 180);
    check("rst_x7", int'(Platform_X_out[7]), 420);
    check("rst_y7", int'(Platform_Y_out[7]), 420);
    check("rst_busy", int'(busy), 0);
    check("rst_moving", int'(Platform_moving), 8'b1010_1010);
    compare_all("rst");

    do_pass(0, 1'b0, 1'b1, "p1");
    check("p1_x1", int'(Platform_X_out[1]), 182);
    check("p1_x0", int'(Platform_X_out[0]), 140);
    check("p1_x7", int'(Platform_X_out[7]), 422);

    for (int k = 2; k <= 10; k++) do_pass(int'($urandom_range(0, 15)), 1'b0, 1'b0, "noscr");
    check("p10_x7", int'(Platform_X_out[7]), 440);
    do_pass(0, 1'b0, 1'b0, "p11");
    check("p11_x7", int'(Platform_X_out[7]), 438);

    for (int k = 0; k < 4; k++) begin
      do_pass(15, 1'b1, 1'b0, "scr");
      check($sformatf("scr_y7_%0d", k), int'(Platform_Y_out[7]), y7exp[k]);
    end
    check("scr_x7_range", int'(Platform_X_out[7] >= 10'd140 && Platform_X_out[7] <= 10'd440), 1);
    check("scr_y0", int'(Platform_Y_out[0]), 60);

    for (int k = 0; k < 16; k++)
      do_pass(int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), k == 0, "rnd");

    // Second tick inside a pass is dropped with an overrun pulse.
    @(negedge Clk);
    frame_tick = 1'b1; scroll_valid = 1'b1; scroll_px = 4'd7;
    tc = cyc;
    @(negedge Clk); frame_tick = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    frame_tick = 1'b1; scroll_px = 4'd3;
    #1 check("ovr_pulse", int'(overrun), 1);
    @(negedge Clk); frame_tick = 1'b0;
    #1 check("ovr_clear", int'(overrun), 0);
    dones = 0;
    for (int k = 0; k < 14; k++) begin @(negedge Clk); if (frame_done) dones++; end
    check("ovr_dones", dones, 1);
    check("ovr_idle", int'(busy), 0);
    model_pass(tc, 7);
    compare_all("ovr");

    // Asynchronous reset in the middle of a pass.
    @(negedge Clk);
    frame_tick = 1'b1; scroll_valid = 1'b1; scroll_px = 4'd9;
    @(negedge Clk); frame_tick = 1'b0;
    repeat (4) @(negedge Clk);
    #2 Reset = 1'b1;
    #1;
    model_layout();
    check("mid_rst_busy", int'(busy), 0);
    compare_all("mid_rst");
    @(negedge Clk); @(negedge Clk);
    Reset = 1'b0;
    do_pass(5, 1'b1, 1'b1, "post_rst");

    // init during a pass aborts it without frame_done.
    @(negedge Clk);
    frame_tick = 1'b1; scroll_valid = 1'b1; scroll_px = 4'd12;
    @(negedge Clk); frame_tick = 1'b0;
    @(negedge Clk); @(negedge Clk);
    init = 1'b1;
    @(negedge Clk); init = 1'b0;
    dones = 0;
    for (int k = 0; k < 12; k++) begin if (frame_done) dones++; @(negedge Clk); end
    check("init_abort_dones", dones, 0);
    check("init_abort_busy", int'(busy), 0);
    model_layout();
    compare_all("init_abort");

    // init and tick together: init wins, no overrun, no pass.
    do_pass(2, 1'b1, 1'b0, "pre_both");
    @(negedge Clk);
    frame_tick = 1'b1; init = 1'b1;
    #1 check("both_overrun", int'(overrun), 0);
    @(negedge Clk); frame_tick = 1'b0; init = 1'b0;
    check("both_busy", int'(busy), 0);
    dones = 0;
    for (int k = 0; k < 12; k++) begin if (frame_done || busy) dones++; @(negedge Clk); end
    check("both_no_pass", dones, 0);
    model_layout();
    compare_all("both");

    do_pass(13, 1'b1, 1'b1, "final");

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
